axilite_write_ctrl: RTL and testbench

This block is the write-path sequencer for the AXI-lite register slave. It captures AW and W beats in either order, decodes the address, and issues one internal register write strobe. It then waits for the register file's acknowledge, or times out, and hands the 2-bit result to `axilite_bresp` through `resp`/`resp_valid`. It holds off the next write until the B handshake for the current one completes, so at most one write is outstanding.

---
 rtl/axilite_write_ctrl.sv | 164 ++++++++++++++++
 tb/tb_axilite_write_ctrl.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/axilite_write_ctrl.sv
// Write-path sequencer for the AXI-lite register slave: joins AW/W beats, decodes,
// strobes the register file, waits for ack or timeout, and reports the B response.
module axilite_write_ctrl #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 32,
  parameter int REG_COUNT      = 16,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ADDR_WIDTH-1:0]     awaddr,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wvalid,
  output logic                      wready,
  output logic                      wr_en,
  output logic [ADDR_WIDTH-3:0]     wr_addr,
  output logic [DATA_WIDTH-1:0]     wr_data,
  output logic [DATA_WIDTH/8-1:0]   wr_strb,
  input  logic                      wr_ack,
  input  logic                      wr_err,
  output logic [1:0]                resp,
  output logic                      resp_valid,
  input  logic                      bvalid,
  input  logic                      bready
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int CNT_W  = $clog2(TIMEOUT_CYCLES) + 1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_ACK,
    RESP,
    WAIT_B
  } state_t;

  state_t                  state, state_nxt;
  logic                    aw_held, w_held;
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [CNT_W-1:0]        cnt;
  logic                    aw_hs, w_hs, b_hs;
  logic [1:0]              dec_resp;
  logic                    resp_ld;
  logic [1:0]              resp_nxt;

  // Out-of-range wins over misalignment; OKAY means the write may be issued.
  function automatic logic [1:0] decode_resp(input logic [ADDR_WIDTH-1:0] a);
    logic [31:0] idx;
    idx = 32'(a[ADDR_WIDTH-1:2]);
    if (idx >= 32'(REG_COUNT))
      return RESP_DECERR;
    else if (a[1:0] != 2'b00)
      return RESP_SLVERR;
    else
      return RESP_OKAY;
  endfunction

  function automatic logic [1:0] ack_resp(input logic err);
    return err ? RESP_SLVERR : RESP_OKAY;
  endfunction

  assign awready  = (state == IDLE) && !aw_held;
  assign wready   = (state == IDLE) && !w_held;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign b_hs     = bvalid && bready;
  assign dec_resp = decode_resp(addr_q);
  assign wr_addr  = addr_q[ADDR_WIDTH-1:2];

  always_comb begin
    state_nxt  = state;
    wr_en      = 1'b0;
    resp_valid = 1'b0;
    resp_ld    = 1'b0;
    resp_nxt   = resp;
    case (state)
      IDLE: begin
        if ((aw_held || aw_hs) && (w_held || w_hs))
          state_nxt = ISSUE;
      end
      ISSUE: begin
        if (dec_resp != RESP_OKAY) begin
          resp_ld   = 1'b1;
          resp_nxt  = dec_resp;
          state_nxt = RESP;
        end else begin
          wr_en = 1'b1;
          if (wr_ack) begin
            resp_ld   = 1'b1;
            resp_nxt  = ack_resp(wr_err);
            state_nxt = RESP;
          end else begin
            state_nxt = WAIT_ACK;
          end
        end
      end
      WAIT_ACK: begin
        // An ack arriving on the last allowed cycle still beats the timeout.
        if (wr_ack) begin
          resp_ld   = 1'b1;
          resp_nxt  = ack_resp(wr_err);
          state_nxt = RESP;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          resp_ld   = 1'b1;
          resp_nxt  = RESP_SLVERR;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = WAIT_B;
      end
      WAIT_B: begin
        if (b_hs)
          state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      cnt     <= '0;
      resp    <= RESP_OKAY;
      addr_q  <= '0;
      wr_data <= '0;
      wr_strb <= '0;
    end else begin
      state <= state_nxt;
      if (aw_hs) begin
        aw_held <= 1'b1;
        addr_q  <= awaddr;
      end
      if (w_hs) begin
        w_held  <= 1'b1;
        wr_data <= wdata;
        wr_strb <= wstrb[STRB_W-1:0];
      end
      if ((state == WAIT_B) && b_hs) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
      // Counts every ack-less cycle from the wr_en cycle onward.
      if (state == IDLE)
        cnt <= '0;
      else if (((state == ISSUE) || (state == WAIT_ACK)) && !wr_ack)
        cnt <= cnt + 1'b1;
      if (resp_ld)
        resp <= resp_nxt;
    end
  end

endmodule

// File: tb/tb_axilite_write_ctrl.sv
// Randomized bench for axilite_write_ctrl against a transaction-level response model.
module tb_axilite_write_ctrl;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int SW = DW / 8;
  localparam int RC = 16;
  localparam int TO = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] awaddr;
  logic          awvalid;
  logic          awready;
  logic [DW-1:0] wdata;
  logic [SW-1:0] wstrb;
  logic          wvalid;
  logic          wready;
  logic          wr_en;
  logic [AW-3:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [SW-1:0] wr_strb;
  logic          wr_ack;
  logic          wr_err;
  logic [1:0]    resp;
  logic          resp_valid;
  logic          bvalid;
  logic          bready;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW-1:0] p_addr;
  logic [DW-1:0] p_data;
  logic [SW-1:0] p_strb;

  axilite_write_ctrl #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .REG_COUNT(RC), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .wr_strb(wr_strb),
    .wr_ack(wr_ack), .wr_err(wr_err),
    .resp(resp), .resp_valid(resp_valid),
    .bvalid(bvalid), .bready(bready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One AXI write. ack_dly < 0 means the register file never acks; otherwise
  // the ack pulse lands ack_dly cycles after the wr_en cycle. With prearm set,
  // the next write's AW/W (p_*) are presented as soon as the response goes out.
  task automatic run_txn(input logic [AW-1:0] addr, input logic [DW-1:0] data,
                         input logic [SW-1:0] strb, input int aw_dly, input int w_dly,
                         input int ack_dly, input logic err, input int b_dly,
                         input bit prearm);
    bit aw_done = 0, w_done = 0, b_done = 0, armed = 0, ok;
    int hs_cyc = -1, en_cyc = -1, rv_cyc = -1, exp_rv = -1, n_en = 0, n_rv = 0;
    int word;
    logic [1:0] exp_resp;
    word = int'(addr) / 4;
    ok   = 1'b0;
    if (word >= RC)             exp_resp = 2'b11;
    else if (int'(addr) % 4 != 0) exp_resp = 2'b10;
    else begin
      ok = 1'b1;
      if (ack_dly >= 0 && ack_dly <= TO - 1) exp_resp = err ? 2'b10 : 2'b00;
      else                                   exp_resp = 2'b10;
    end
    for (int c = 0; c < 300 && !b_done; c++) begin
      @(negedge clk);
      chk("awready", awready, !aw_done);
      chk("wready", wready, !w_done);
      if (wr_en) begin
        n_en++;
        en_cyc = c;
        chk("wr_en_cycle", c, hs_cyc + 1);
        chk("wr_addr", wr_addr, word);
        chk("wr_data", wr_data, data);
        chk("wr_strb", wr_strb, strb);
        if (ack_dly >= 0 && ack_dly <= TO - 1) exp_rv = c + ack_dly + 1;
        else                                   exp_rv = c + TO;
      end
      if (resp_valid) begin
        n_rv++;
        rv_cyc = c;
        chk("resp", resp, exp_resp);
        chk("resp_cycle", c, exp_rv);
      end
      wr_ack = (en_cyc >= 0 && ack_dly >= 0 && c == en_cyc + ack_dly);
      wr_err = wr_ack ? err : 1'($urandom);
      if (prearm && rv_cyc >= 0) armed = 1;
      if (armed) begin
        awvalid = 1'b1; awaddr = p_addr;
        wvalid  = 1'b1; wdata  = p_data; wstrb = p_strb;
      end else begin
        if (!aw_done && c >= aw_dly) begin awvalid = 1'b1; awaddr = addr; end
        else begin awvalid = 1'b0; awaddr = AW'($urandom); end
        if (!w_done && c >= w_dly) begin wvalid = 1'b1; wdata = data; wstrb = strb; end
        else begin wvalid = 1'b0; wdata = $urandom; wstrb = SW'($urandom); end
        if (awvalid && awready) aw_done = 1;
        if (wvalid && wready) w_done = 1;
        if (aw_done && w_done && hs_cyc < 0) begin
          hs_cyc = c;
          if (!ok) exp_rv = c + 2;
        end
      end
      bvalid = (rv_cyc >= 0 && c > rv_cyc);
      bready = bvalid && (c >= rv_cyc + 1 + b_dly);
      if (bvalid && bready) begin
        b_done = 1;
        chk("resp_held", resp, exp_resp);
      end
    end
    if (!b_done) chk("txn_timeout", 0, 1);
    chk("wr_en_count", n_en, ok ? 1 : 0);
    chk("resp_valid_count", n_rv, 1);
  endtask

  task automatic reset_mid_wait();
    int n_rv = 0, n_en = 0;
    @(negedge clk);
    bvalid = 0; bready = 0; wr_ack = 0;
    awvalid = 1; awaddr = 8'h14; wvalid = 1; wdata = 32'h1234_5678; wstrb = 4'hF;
    @(negedge clk);
    awvalid = 0; wvalid = 0;
    chk("rst_txn_wr_en", wr_en, 1);
    repeat (3) @(negedge clk);
    rst = 1; wr_ack = 1; wr_err = 0;
    #1;
    chk("rst_awready", awready, 1);
    chk("rst_wready", wready, 1);
    chk("rst_resp_valid", resp_valid, 0);
    chk("rst_wr_data", wr_data, 0);
    @(negedge clk);
    rst = 0;
    for (int i = 0; i < TO + 4; i++) begin
      @(negedge clk);
      wr_ack = 0;
      n_rv += int'(resp_valid);
      n_en += int'(wr_en);
    end
    chk("post_rst_resp_valid", n_rv, 0);
    chk("post_rst_wr_en", n_en, 0);
    chk("post_rst_awready", awready, 1);
    chk("post_rst_wready", wready, 1);
  endtask

  initial begin
    rst = 1; awaddr = 0; awvalid = 0; wdata = 0; wstrb = 0; wvalid = 0;
    wr_ack = 0; wr_err = 0; bvalid = 0; bready = 0;
    repeat (2) @(negedge clk);
    chk("reset_awready", awready, 1);
    chk("reset_wready", wready, 1);
    chk("reset_wr_en", wr_en, 0);
    chk("reset_resp_valid", resp_valid, 0);
    chk("reset_resp", resp, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_wr_strb", wr_strb, 0);
    rst = 0;

    run_txn(8'h04, 32'hDEADBEEF, 4'hF, 0, 0, 0, 1'b0, 0, 0);
    run_txn(8'h08, 32'hCAFE_F00D, 4'h5, 3, 0, 2, 1'b1, 1, 0);
    run_txn(8'h40, 32'h1111_1111, 4'hF, 0, 0, 0, 1'b0, 0, 0);
    run_txn(8'h06, 32'h2222_2222, 4'hF, 1, 0, 0, 1'b0, 0, 0);
    run_txn(8'h0C, 32'h3333_3333, 4'hF, 0, 2, -1, 1'b0, 2, 0);
    run_txn(8'h10, 32'h4444_4444, 4'hA, 0, 0, TO + 1, 1'b0, 4, 0);
    run_txn(8'h3C, 32'h5555_5555, 4'hF, 0, 0, TO - 1, 1'b0, 0, 0);
    run_txn(8'h00, 32'h6666_6666, 4'hF, 0, 0, TO, 1'b0, 0, 0);

    p_addr = 8'h18; p_data = 32'hA5A5_5A5A; p_strb = 4'h3;
    run_txn(8'h14, 32'h7777_7777, 4'hF, 0, 0, 1, 1'b0, 10, 1);
    run_txn(p_addr, p_data, p_strb, 0, 0, 0, 1'b0, 0, 0);

    reset_mid_wait();
    run_txn(8'h20, 32'h8888_8888, 4'hC, 0, 1, 0, 1'b0, 0, 0);

    for (int t = 0; t < 40; t++) begin
      logic [AW-1:0] a;
      int kind, ad;
      kind = int'($urandom_range(0, 3));
      if (kind <= 1)      a = AW'($urandom_range(0, RC - 1) * 4);
      else if (kind == 2) a = AW'($urandom_range(0, RC - 1) * 4 + $urandom_range(1, 3));
      else                a = AW'($urandom_range(RC * 4, 255));
      ad = ($urandom_range(0, 7) == 0) ? -1 : int'($urandom_range(0, TO + 2));
      run_txn(a, $urandom, SW'($urandom), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 4)), ad, 1'($urandom), int'($urandom_range(0, 3)), 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
